fpga_tb_top_sim: RTL and testbench
==================================

FPGA_TB_TOP_SIM -- requirements
Module: fpga_tb_top_sim

Interface
REQ-001 Parameter SPI_HALF_DIV, default 1: s_clk cycles per spi_sck half period, legal range 1..255.
REQ-002 Parameter JTAG_HALF_DIV, default 4: s_clk cycles per tck half period, legal range 1..255.
REQ-003 Parameter BOOT_WORDS, default 4: 32-bit words streamed over SPI, legal range 1..256.
REQ-004 Parameter EXP_IDCODE, default 32'h249511C3: expected JTAG IDCODE.
REQ-005 Parameter TIMEOUT, default 4096: s_clk cycles allowed for eoc after fetch_en.
REQ-006 The block has one clock; reset is asynchronous and active-high.
REQ-007 s_clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 chip_rst_n  out  1  active-low reset to the chip under test.
REQ-010 tck, tms, tdi  out  1 each  JTAG master outputs; tdo  in  1  JTAG data from the chip.
REQ-011 spi_sck, spi_csn, spi_mosi  out  1 each  SPI master outputs; spi_miso  in  1  unused, ignored.
REQ-012 fetch_en  out  1  instruction fetch enable to the chip; eoc  in  1  chip end-of-computation, asynchronous.
REQ-013 done  out  1  sequence finished; pass  out  1  result valid when done=1; idcode  out  32  captured IDCODE.

Function
REQ-014 tck and spi_sck are produced by clock-enable counters on s_clk; no derived clocks.
REQ-015 FSM states: CHIP_RST, JTAG_TLR, JTAG_SHIFT, JTAG_EXIT, SPI_LOAD, RUN, FIN.
REQ-016 CHIP_RST: chip_rst_n is held 0 for 16 s_clk cycles after rst deasserts, then set to 1; the FSM moves to JTAG_TLR in the same cycle.
REQ-017 JTAG timing: tms and tdi change only on tck falling edges; tdo is sampled on tck rising edges; tck idles 0.
REQ-018 JTAG_TLR: 5 tck rising edges with tms=1, then tms sequence 0,1,0,0 (Run-Test-Idle, Select-DR, Capture-DR, Shift-DR).
REQ-019 JTAG_SHIFT: 32 tck rising edges with tdi=0; tdo is captured LSB first into idcode; tms=1 on the 32nd edge only.
REQ-020 JTAG_EXIT: tms sequence 1,0 (Update-DR, Run-Test-Idle), then tck stops at 0.
REQ-021 If idcode != EXP_IDCODE, go to FIN with pass=0; spi_csn never goes low.
REQ-022 If idcode matches, go to SPI_LOAD.
REQ-023 SPI_LOAD uses SPI mode 0, MSB first, one transaction:
- 8-bit command 8'h02, then 32-bit address 32'h0000_0000.
- Then BOOT_WORDS words; word i = {16'hA5A5, i[15:0]}.
- Total 40+32*BOOT_WORDS spi_sck rising edges.
REQ-024 SPI framing:
- spi_csn falls one half period before the first spi_sck rise.
- spi_mosi changes only while spi_sck is low.
- spi_csn rises one half period after the last spi_sck fall.
REQ-025 RUN: fetch_en=1 in the cycle after spi_csn rises; eoc passes through a 2-flop synchronizer.
REQ-026 RUN exit: synchronized eoc=1 -> FIN with pass=1; TIMEOUT cycles elapsed without it -> FIN with pass=0.
REQ-027 FIN: done=1; fetch_en stays 1; all other outputs hold their idle values; the FSM remains in FIN until rst.

Reset
REQ-028 While rst=1, outputs take these values immediately (asynchronously):
- chip_rst_n=0, tck=0, tms=1, tdi=0.
- spi_sck=0, spi_csn=1, spi_mosi=0.
- fetch_en=0, done=0, pass=0, idcode=0.
REQ-029 rst asserted in any state, including mid-JTAG or mid-SPI, aborts the sequence; after release the full sequence restarts from CHIP_RST.

Verification
REQ-030 rst high 10 cycles then low -> chip_rst_n rises exactly 16 s_clk cycles after release; all other outputs at reset values until then.
REQ-031 JTAG model returns 32'h249511C3 -> idcode=32'h249511C3 and spi_csn falls; with tdo=0 -> done=1, pass=0, spi_csn stays 1.
REQ-032 SPI slave model, BOOT_WORDS=4 -> 168 spi_sck rises; decodes 8'h02, 32'h0, then 32'hA5A50000..32'hA5A50003.
REQ-033 eoc raised 100 cycles after fetch_en -> done=1, pass=1 within 3 cycles; eoc never raised -> done=1, pass=0 after TIMEOUT cycles.
REQ-034 rst pulsed during the 50th spi_sck cycle -> spi_csn=1 and fetch_en=0 immediately; after release the sequence restarts and passes.

Source files
------------

// File: rtl/fpga_tb_top_sim.sv
`timescale 1ns/1ps
// fpga_tb_top_sim
// Boot sequencer for a chip under test. It holds the chip in reset, reads the
// JTAG IDCODE, streams a boot image over SPI, starts instruction fetch and then
// waits for end-of-computation (or a timeout). tck and spi_sck are generated
// from s_clk with clock-enable dividers, so the whole block runs on one clock.
//
// Ports
//   s_clk       in   sole clock
//   rst         in   asynchronous active-high reset; aborts and restarts the sequence
//   chip_rst_n  out  active-low reset to the chip
//   tck/tms/tdi out  JTAG master; tdo in, sampled on tck rising edges
//   spi_sck/spi_csn/spi_mosi out  SPI mode-0 master, MSB first; spi_miso ignored
//   fetch_en    out  fetch enable to the chip; eoc in (asynchronous, synchronized here)
//   done/pass   out  sequence finished / result
//   idcode      out  IDCODE captured over JTAG
module fpga_tb_top_sim #(
  parameter int          SPI_HALF_DIV  = 1,
  parameter int          JTAG_HALF_DIV = 4,
  parameter int          BOOT_WORDS    = 4,
  parameter logic [31:0] EXP_IDCODE    = 32'h249511C3,
  parameter int          TIMEOUT       = 4096
) (
  input  logic        s_clk,
  input  logic        rst,
  output logic        chip_rst_n,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        fetch_en,
  input  logic        eoc,
  output logic        done,
  output logic        pass,
  output logic [31:0] idcode
);

  localparam int NBITS = 40 + 32 * BOOT_WORDS;
  localparam int SBW   = $clog2(NBITS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    CHIP_RST, JTAG_TLR, JTAG_SHIFT, JTAG_EXIT, SPI_LOAD, RUN, FIN
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     crst;
  logic [7:0]     div;
  logic [5:0]     jrise;
  logic [SBW-1:0] sbit, sbit_nxt;
  logic [TW-1:0]  tcnt;
  logic           eoc_p0, eoc_p1;
  logic           tick_j, tick_s;
  logic           unused_miso;

  assign unused_miso = spi_miso;
  assign tdi         = 1'b0;
  assign tick_j      = (div == 8'(JTAG_HALF_DIV - 1));
  assign tick_s      = (div == 8'(SPI_HALF_DIV - 1));
  assign sbit_nxt    = sbit + 1'b1;

  // tms value to present before rising edge k (k counts from 0 over the whole
  // JTAG phase): 5x TLR, RTI/Select-DR/Capture-DR/Shift-DR, 32 shift edges
  // leaving on the last, then Update-DR and back to Run-Test-Idle.
  function automatic logic tms_for(input logic [5:0] k);
    tms_for = (k < 6'd5) || (k == 6'd6) || (k == 6'd40) || (k == 6'd41);
  endfunction

  // Serial bit b of the SPI frame: command 8'h02, zero address, then boot words
  // {16'hA5A5, index}, all MSB first.
  function automatic logic spi_bit(input logic [15:0] b);
    logic [7:0]  cmd;
    logic [15:0] off;
    logic [31:0] word;
    cmd  = 8'h02;
    off  = b - 16'd40;
    word = {16'hA5A5, 5'd0, off[15:5]};
    if (b < 16'd8)       spi_bit = cmd[~b[2:0]];
    else if (b < 16'd40) spi_bit = 1'b0;
    else                 spi_bit = word[~off[4:0]];
  endfunction

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) state_q <= CHIP_RST;
    else     state_q <= state_d;
  end

  // JTAG transitions happen on tck falling edges; jrise already counts the
  // rising edge just completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHIP_RST:   if (crst == 4'd15) state_d = JTAG_TLR;
      JTAG_TLR:   if (tick_j && tck && jrise == 6'd9) state_d = JTAG_SHIFT;
      JTAG_SHIFT: if (tick_j && tck && jrise == 6'd41) state_d = JTAG_EXIT;
      JTAG_EXIT:  if (tick_j && tck && jrise == 6'd43)
                    state_d = (idcode == EXP_IDCODE) ? SPI_LOAD : FIN;
      SPI_LOAD:   if (tick_s && !spi_sck && sbit == SBW'(NBITS)) state_d = RUN;
      RUN:        if (fetch_en && (eoc_p1 || tcnt == TW'(TIMEOUT - 1))) state_d = FIN;
      FIN:        state_d = FIN;
      default:    state_d = CHIP_RST;
    endcase
  end

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      chip_rst_n <= 1'b0;
      tck        <= 1'b0;
      tms        <= 1'b1;
      spi_sck    <= 1'b0;
      spi_csn    <= 1'b1;
      spi_mosi   <= 1'b0;
      fetch_en   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      idcode     <= '0;
      crst       <= '0;
      div        <= '0;
      jrise      <= '0;
      sbit       <= '0;
      tcnt       <= '0;
      eoc_p0     <= 1'b0;
      eoc_p1     <= 1'b0;
    end else begin
      // eoc synchronizer stage 0 -> stage 1
      eoc_p0 <= eoc;
      eoc_p1 <= eoc_p0;

      case (state_q)
        CHIP_RST: begin
          crst <= crst + 4'd1;
          div  <= '0;
          if (crst == 4'd15) chip_rst_n <= 1'b1;
        end
        JTAG_TLR, JTAG_SHIFT, JTAG_EXIT: begin
          if (tick_j) begin
            div <= '0;
            if (!tck) begin
              tck   <= 1'b1;
              jrise <= jrise + 6'd1;
              if (jrise >= 6'd9 && jrise <= 6'd40) idcode <= {tdo, idcode[31:1]};
            end else begin
              tck <= 1'b0;
              tms <= tms_for(jrise);
            end
          end else begin
            div <= div + 8'd1;
          end
          // csn drops and the first bit is presented one half period ahead of
          // the first sck rise.
          if (state_d == SPI_LOAD) begin
            spi_csn  <= 1'b0;
            spi_mosi <= spi_bit(16'd0);
            sbit     <= '0;
          end
        end
        SPI_LOAD: begin
          if (tick_s) begin
            div <= '0;
            if (!spi_sck) begin
              if (sbit == SBW'(NBITS)) spi_csn <= 1'b1;
              else                     spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              sbit    <= sbit_nxt;
              if (sbit_nxt < SBW'(NBITS)) spi_mosi <= spi_bit(16'(sbit_nxt));
              else                        spi_mosi <= 1'b0;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        RUN: begin
          if (!fetch_en) begin
            fetch_en <= 1'b1;
            tcnt     <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase

      if (state_d == FIN && state_q != FIN) begin
        done <= 1'b1;
        pass <= (state_q == RUN) && eoc_p1;
      end
    end
  end

endmodule

// File: tb/tb_fpga_tb_top_sim.sv
`timescale 1ns/1ps
// Bench for fpga_tb_top_sim: a JTAG TAP model supplies the IDCODE, an SPI
// slave decodes the boot frame, and a negedge monitor pops expected frame
// fields and end results from scoreboard queues filled by the stimulus.
module tb_fpga_tb_top_sim;

  localparam int          SPI_HALF  = 1;
  localparam int          JTAG_HALF = 4;
  localparam int          BW        = 4;
  localparam logic [31:0] CHIP_ID   = 32'h249511C3;
  localparam int          TMO       = 4096;
  localparam logic [9:0]  RST_OUTS  = 10'b0010010000;

  logic s_clk = 1'b0, rst = 1'b0, spi_miso = 1'b0, eoc = 1'b0, tdo;
  logic chip_rst_n, tck, tms, tdi, spi_sck, spi_csn, spi_mosi, fetch_en, done, pass;
  logic [31:0] idcode;

  always #5 s_clk = ~s_clk;

  fpga_tb_top_sim #(
    .SPI_HALF_DIV(SPI_HALF), .JTAG_HALF_DIV(JTAG_HALF), .BOOT_WORDS(BW),
    .EXP_IDCODE(CHIP_ID), .TIMEOUT(TMO)
  ) dut (
    .s_clk(s_clk), .rst(rst), .chip_rst_n(chip_rst_n),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .fetch_en(fetch_en), .eoc(eoc), .done(done), .pass(pass), .idcode(idcode)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [9:0] outs();
    return {chip_rst_n, tck, tms, tdi, spi_sck, spi_csn, spi_mosi, fetch_en, done, pass};
  endfunction

  // ---------------- JTAG TAP model ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PAUSEDR;
      PAUSEDR: return m ? EX2DR : PAUSEDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAUSEIR;
      PAUSEIR: return m ? EX2IR : PAUSEIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  tap_t        tap = TLR;
  logic [31:0] dr = '0;
  logic        tdo_m = 1'b0, tdo_zero = 1'b0;

  always @(posedge tck) begin
    if (tap == CAPDR)     dr <= CHIP_ID;
    else if (tap == SHDR) dr <= {tdi, dr[31:1]};
    tap <= tap_next(tap, tms);
  end
  always @(negedge tck) tdo_m <= (tap == SHDR) ? dr[0] : 1'b0;
  assign tdo = tdo_zero ? 1'b0 : tdo_m;

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_spi[$];
  logic [32:0] exp_done[$];

  task automatic push_frame();
    exp_spi.push_back(32'h0000_0002);
    exp_spi.push_back(32'h0000_0000);
    exp_spi.push_back(32'hA5A5_0000);
    exp_spi.push_back(32'hA5A5_0001);
    exp_spi.push_back(32'hA5A5_0002);
    exp_spi.push_back(32'hA5A5_0003);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, rises = 0, nbits = 0, csn_fall_cyc = 0, last_fall_cyc = 0, sviol = 0, tviol = 0;
  logic [31:0] sh = '0;
  logic rst_p = 1'b1, sck_p = 1'b0, csn_p = 1'b1, mosi_p = 1'b0, tck_p = 1'b0, tms_p = 1'b1, done_p = 1'b0;

  always @(negedge s_clk) begin : mon
    logic [31:0] exp_w;
    logic [32:0] exp_d;
    cyc++;
    if (rst) begin
      rises = 0;
      nbits = 0;
    end else begin
      if (!rst_p) begin
        if (spi_mosi !== mosi_p && spi_sck) sviol++;
        if (tms !== tms_p && !(tck_p && !tck)) tviol++;
      end
      if (csn_p && !spi_csn) begin
        csn_fall_cyc = cyc;
        rises = 0;
        nbits = 0;
      end
      if (!spi_csn && spi_sck && !sck_p) begin
        rises++;
        if (rises == 1) check("csn_to_first_sck", cyc - csn_fall_cyc, SPI_HALF);
        sh = {sh[30:0], spi_mosi};
        nbits++;
        if (nbits == 8 || (nbits > 8 && (nbits - 8) % 32 == 0)) begin
          if (exp_spi.size() == 0) begin
            checks++; errors++;
            $display("FAIL spi_unexpected_field: actual %0h required none", sh);
          end else begin
            exp_w = exp_spi.pop_front();
            check("spi_field", (nbits == 8) ? {24'h0, sh[7:0]} : sh, exp_w);
          end
        end
      end
      if (!spi_sck && sck_p) last_fall_cyc = cyc;
      if (!csn_p && spi_csn) begin
        check("sck_rises_per_frame", rises, 168);
        check("last_fall_to_csn", cyc - last_fall_cyc, SPI_HALF);
        check("mosi_changes_while_low", sviol, 0);
      end
      if (done && !done_p) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: actual pass=%0b required none", pass);
        end else begin
          exp_d = exp_done.pop_front();
          check("result_pass", pass, exp_d[32]);
          check("result_idcode", idcode, exp_d[31:0]);
        end
        check("tms_on_tck_fall", tviol, 0);
      end
    end
    rst_p = rst; sck_p = spi_sck; csn_p = spi_csn; mosi_p = spi_mosi;
    tck_p = tck; tms_p = tms; done_p = done;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    int early;
    rst = 1'b1;
    eoc = 1'b0;
    repeat (10) @(negedge s_clk);
    check("reset_outputs", outs(), RST_OUTS);
    check("reset_idcode", idcode, 32'h0);
    rst = 1'b0;
    early = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge s_clk);
      if (i < 16 && outs() !== RST_OUTS) early++;
    end
    check("idle_until_chip_rst", early, 0);
    check("chip_rst_n_after_16", chip_rst_n, 1'b1);
  endtask

  task automatic wait_fetch();
    int n;
    for (n = 0; n < 3000 && !fetch_en; n++) @(negedge s_clk);
    check("fetch_en_reached", fetch_en, 1'b1);
  endtask

  task automatic eoc_run();
    int n;
    repeat (100) @(negedge s_clk);
    eoc = 1'b1;
    for (n = 0; n < 3 && !done; n++) @(negedge s_clk);
    check("done_within_3", done, 1'b1);
    check("pass_after_eoc", pass, 1'b1);
  endtask

  task automatic finish_checks(input logic fe);
    @(negedge s_clk);
    check("tap_in_rti", tap, RTI);
    check("fin_fetch_en", fetch_en, fe);
    check("fin_csn_idle", spi_csn, 1'b1);
    check("spi_queue_drained", exp_spi.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
  endtask

  initial begin
    int n, lowseen;

    // good IDCODE, full boot, eoc after 100 cycles
    tdo_zero = 1'b0;
    push_frame();
    exp_done.push_back({1'b1, 32'h249511C3});
    do_reset();
    wait_fetch();
    eoc_run();
    finish_checks(1'b1);

    // tdo stuck low: IDCODE mismatch, no SPI traffic
    tdo_zero = 1'b1;
    exp_done.push_back({1'b0, 32'h0000_0000});
    do_reset();
    lowseen = 0;
    for (n = 0; n < 2000 && !done; n++) begin
      @(negedge s_clk);
      if (!spi_csn) lowseen++;
    end
    check("bad_id_done", done, 1'b1);
    check("bad_id_pass", pass, 1'b0);
    check("bad_id_csn_never_low", lowseen, 0);
    finish_checks(1'b0);

    // eoc never arrives: timeout
    tdo_zero = 1'b0;
    push_frame();
    exp_done.push_back({1'b0, 32'h249511C3});
    do_reset();
    wait_fetch();
    for (n = 0; n < TMO + 50 && !done; n++) @(negedge s_clk);
    check("timeout_window", (n >= TMO && n <= TMO + 3), 1'b1);
    check("timeout_pass", pass, 1'b0);
    finish_checks(1'b1);

    // reset during the 50th sck cycle, then full restart
    exp_spi.push_back(32'h0000_0002);
    exp_spi.push_back(32'h0000_0000);
    do_reset();
    for (n = 0; n < 3000 && rises < 50; n++) begin
      @(negedge s_clk);
      #1;
    end
    check("reached_sck_50", rises, 50);
    rst = 1'b1;
    #1;
    check("abort_csn", spi_csn, 1'b1);
    check("abort_fetch_en", fetch_en, 1'b0);
    check("abort_sck", spi_sck, 1'b0);
    @(negedge s_clk);
    check("abort_queue_drained", exp_spi.size(), 0);
    push_frame();
    exp_done.push_back({1'b1, 32'h249511C3});
    do_reset();
    wait_fetch();
    eoc_run();
    finish_checks(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog");
  end

endmodule
